// File: rtl/bvinv_skolem_seq_if.sv
// Request/result handshake bundle for the digit-serial bit-vector inversion block.
// The master side produces requests and consumes results. The slave side is the solver.
interface bvinv_skolem_seq_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_s;
  logic [W-1:0] in_t;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_x;
  logic         out_ic;

  modport master (
    output in_valid, in_s, in_t, in_mode, out_ready,
    input  in_ready, out_valid, out_x, out_ic
  );

  modport slave (
    input  in_valid, in_s, in_t, in_mode, out_ready,
    output in_ready, out_valid, out_x, out_ic
  );
endinterface

// File: rtl/bvinv_skolem_seq.sv
// Digit-serial Skolem witness generator: finds x with (x op s) == t, LSB digit first,
// and reports whether any such x exists (ic).
module bvinv_skolem_seq #(
  parameter int W     = 8,
  parameter int DIGIT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bvinv_skolem_seq_if.slave    bus
);
  localparam int NDIG = W / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_XOR = 2'd2;

  generate
    if (W < 1 || DIGIT < 1 || (W % DIGIT) != 0) begin : g_bad_params
      $fatal(1, "bvinv_skolem_seq: DIGIT must divide W and W must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   s_q, s_d;
  logic [W-1:0]   t_q, t_d;
  logic [W-1:0]   x_q, x_d;
  logic [1:0]     mode_q, mode_d;
  logic           ic_q, ic_d;
  logic           carry_q, carry_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [DIGIT-1:0] s_dig, t_dig, s_op, x_dig;
  logic [DIGIT:0]   sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      t_q     <= '0;
      x_q     <= '0;
      mode_q  <= '0;
      ic_q    <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      t_q     <= t_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      ic_q    <= ic_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // s and t are shifted right each RUN cycle so the current digit is always at the LSB.
  always_comb begin
    s_dig = s_q[DIGIT-1:0];
    t_dig = t_q[DIGIT-1:0];
    // ADD solves x = t + ~s + 1 (carry seeded to 1); SUB solves x = t + s.
    s_op  = (mode_q == MODE_ADD) ? ~s_dig : s_dig;
    sum   = {1'b0, t_dig} + {1'b0, s_op} + {{DIGIT{1'b0}}, carry_q};
    case (mode_q)
      MODE_ADD, MODE_SUB: x_dig = sum[DIGIT-1:0];
      MODE_XOR:           x_dig = t_dig ^ s_dig;
      default:            x_dig = t_dig;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    t_d          = t_q;
    x_d          = x_q;
    mode_d       = mode_q;
    ic_d         = ic_q;
    carry_d      = carry_q;
    cnt_d        = cnt_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          s_d     = bus.in_s;
          t_d     = bus.in_t;
          mode_d  = bus.in_mode;
          x_d     = '0;
          ic_d    = 1'b1;
          carry_d = (bus.in_mode == MODE_ADD);
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d     = s_q >> DIGIT;
        t_d     = t_q >> DIGIT;
        x_d     = W'({x_dig, x_q} >> DIGIT);
        carry_d = sum[DIGIT];
        if (mode_q == 2'd3 && |(t_dig & ~s_dig)) begin
          ic_d = 1'b0;
        end
        if (cnt_q == CW'(NDIG - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_x  = x_q;
  assign bus.out_ic = ic_q;
endmodule
